// File: rtl/sram_writeback.sv
// sram_writeback
//   Packs a stream of 16-bit results into 32-bit words (first result of a
//   pair in the low half) and writes them to consecutive SRAM word addresses
//   starting at BASE_ADDR. An odd trailing result is flushed with a zero
//   upper half. Each write is held until the SRAM acknowledges it.
//
// Parameters
//   BASE_ADDR    first SRAM word address written by a job
//   NUM_RESULTS  results per job (1..1024)
//
// Ports
//   clk          rising-edge clock
//   n_rst        asynchronous active-low reset
//   start        single-cycle job request (ignored while busy)
//   res_valid    result word present on res_data
//   res_data     16-bit result value
//   res_ready    block accepts res_data this cycle
//   sram_wr_en   SRAM write request
//   sram_addr    SRAM word address
//   sram_wdata   packed 32-bit write data
//   sram_ack     SRAM accepted the current write
//   busy         job in progress
//   done         one-cycle job-complete pulse
module sram_writeback #(
    parameter logic [15:0] BASE_ADDR   = 16'h0400,
    parameter int unsigned NUM_RESULTS = 10
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        res_valid,
    input  logic [15:0] res_data,
    output logic        res_ready,
    output logic        sram_wr_en,
    output logic [15:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_ack,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT_LO,
        COLLECT_HI,
        WRITE,
        DONE
    } state_t;

    localparam logic [10:0] N_LAST = 11'(NUM_RESULTS);

    state_t      state, state_nx;
    logic [10:0] cnt, cnt_nx;
    logic [15:0] addr_nx;
    logic [31:0] wdata_nx;
    logic        ready_nx, wr_en_nx, busy_nx, done_nx;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            res_ready  <= 1'b0;
            sram_wr_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sram_addr  <= addr_nx;
            sram_wdata <= wdata_nx;
            res_ready  <= ready_nx;
            sram_wr_en <= wr_en_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

    // res_ready is registered from the next state, so it is high exactly in
    // the COLLECT states; res_valid alone therefore qualifies a transfer there.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = sram_addr;
        wdata_nx = sram_wdata;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = COLLECT_LO;
                    cnt_nx   = '0;
                    addr_nx  = BASE_ADDR;
                end
            end
            COLLECT_LO: begin
                if (res_valid) begin
                    wdata_nx = {16'h0000, res_data};
                    cnt_nx   = cnt + 11'd1;
                    state_nx = (cnt + 11'd1 == N_LAST) ? WRITE : COLLECT_HI;
                end
            end
            COLLECT_HI: begin
                if (res_valid) begin
                    wdata_nx[31:16] = res_data;
                    cnt_nx          = cnt + 11'd1;
                    state_nx        = WRITE;
                end
            end
            WRITE: begin
                if (sram_ack) begin
                    addr_nx  = sram_addr + 16'd1;
                    state_nx = (cnt == N_LAST) ? DONE : COLLECT_LO;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        ready_nx = (state_nx == COLLECT_LO) || (state_nx == COLLECT_HI);
        wr_en_nx = (state_nx == WRITE);
        busy_nx  = (state_nx == COLLECT_LO) || (state_nx == COLLECT_HI) ||
                   (state_nx == WRITE);
        done_nx  = (state_nx == DONE);
    end

endmodule

// File: tb/tb_sram_writeback.sv
module tb_sram_writeback;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;

    logic        start_v     [3];
    logic        valid_v     [3];
    logic [15:0] data_v      [3];
    logic        ack_v       [3];
    logic        ready_v     [3];
    logic        wr_en_v     [3];
    logic [15:0] addr_v      [3];
    logic [31:0] wdata_v     [3];
    logic        busy_v      [3];
    logic        done_v      [3];

    int          sel = 0;
    logic        o_ready, o_wr_en, o_busy, o_done;
    logic [15:0] o_addr;
    logic [31:0] o_wdata;

    int          cmps = 0;
    int          errs = 0;
    logic [47:0] exp_q  [$];
    logic [15:0] res_in [$];

    always #5 clk = ~clk;

    sram_writeback #(.BASE_ADDR(16'h0400), .NUM_RESULTS(10)) u_n10 (
        .clk(clk), .n_rst(n_rst), .start(start_v[0]), .res_valid(valid_v[0]),
        .res_data(data_v[0]), .res_ready(ready_v[0]), .sram_wr_en(wr_en_v[0]),
        .sram_addr(addr_v[0]), .sram_wdata(wdata_v[0]), .sram_ack(ack_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    sram_writeback #(.BASE_ADDR(16'h0400), .NUM_RESULTS(3)) u_n3 (
        .clk(clk), .n_rst(n_rst), .start(start_v[1]), .res_valid(valid_v[1]),
        .res_data(data_v[1]), .res_ready(ready_v[1]), .sram_wr_en(wr_en_v[1]),
        .sram_addr(addr_v[1]), .sram_wdata(wdata_v[1]), .sram_ack(ack_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    sram_writeback #(.BASE_ADDR(16'hFFFF), .NUM_RESULTS(4)) u_wrap (
        .clk(clk), .n_rst(n_rst), .start(start_v[2]), .res_valid(valid_v[2]),
        .res_data(data_v[2]), .res_ready(ready_v[2]), .sram_wr_en(wr_en_v[2]),
        .sram_addr(addr_v[2]), .sram_wdata(wdata_v[2]), .sram_ack(ack_v[2]),
        .busy(busy_v[2]), .done(done_v[2])
    );

    always_comb begin
        o_ready = ready_v[sel];
        o_wr_en = wr_en_v[sel];
        o_addr  = addr_v[sel];
        o_wdata = wdata_v[sel];
        o_busy  = busy_v[sel];
        o_done  = done_v[sel];
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 48'(o_ready), 48'd0);
        check({tag, "_wr_en"}, 48'(o_wr_en), 48'd0);
        check({tag, "_addr"},  48'(o_addr),  48'd0);
        check({tag, "_wdata"}, 48'(o_wdata), 48'd0);
        check({tag, "_busy"},  48'(o_busy),  48'd0);
        check({tag, "_done"},  48'(o_done),  48'd0);
    endtask

    // Runs one job on instance s using the results in res_in.
    // ack_dly: cycles of wr_en before ack is driven; toggle: res_valid 1/0;
    // abort_wr: write index at which reset is pulsed with ack held low (-1 none);
    // dup_cyc: cycle at which a redundant start is driven (-1 none).
    task automatic run_job(input int s, input logic [15:0] base, input int n,
                           input int ack_dly, input bit toggle,
                           input int abort_wr, input int dup_cyc);
        int          idx = 0;
        int          wcnt = 0;
        int          nwr = 0;
        int          ndone = 0;
        int          post = 0;
        int          cyc = 0;
        logic [15:0] lo = '0;
        logic [15:0] cur_addr = base;
        logic [15:0] hold_a = '0;
        logic [31:0] hold_w = '0;
        logic        v;

        sel = s;
        exp_q.delete();
        @(posedge clk); #1;
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        check("busy_after_start", 48'(o_busy), 48'd1);
        check("ready_after_start", 48'(o_ready), 48'd1);

        while (cyc < 2000) begin
            if (o_done) begin
                ndone++;
                check("busy_low_at_done", 48'(o_busy), 48'd0);
            end
            if (ndone > 0) begin
                post++;
                if (post > 4) break;
            end

            if (o_wr_en) begin
                if (wcnt == 0) begin
                    nwr++;
                    hold_a = o_addr;
                    hold_w = o_wdata;
                    check("sb_has_entry", 48'(exp_q.size() != 0), 48'd1);
                    if (exp_q.size() != 0)
                        check("write_addr_data", {o_addr, o_wdata}, exp_q.pop_front());
                end else begin
                    check("write_held_stable", {o_addr, o_wdata}, {hold_a, hold_w});
                end
                check("ready_low_in_write", 48'(o_ready), 48'd0);
                if (abort_wr == nwr - 1 && wcnt == 3) begin
                    check("abort_addr", 48'(o_addr), 48'(base + 16'(abort_wr)));
                    n_rst = 1'b0;
                    #1;
                    check_all_zero("async_reset");
                    @(posedge clk); #1;
                    valid_v[s] = 1'b0;
                    ack_v[s]   = 1'b0;
                    n_rst      = 1'b1;
                    exp_q.delete();
                    return;
                end
                ack_v[s] = (abort_wr != nwr - 1) && (wcnt == ack_dly);
                wcnt++;
            end else begin
                if (wcnt > 0)
                    check("wr_en_cycles", 48'(wcnt), 48'(ack_dly + 1));
                wcnt     = 0;
                ack_v[s] = 1'b0;
            end

            v = (idx < n) && (!toggle || (cyc % 2 == 0));
            valid_v[s] = v;
            data_v[s]  = v ? res_in[idx] : 16'hDEAD;
            if (v && o_ready) begin
                if (idx % 2 == 0) begin
                    lo = res_in[idx];
                    if (idx == n - 1) begin
                        exp_q.push_back({cur_addr, 16'h0000, lo});
                        cur_addr++;
                    end
                end else begin
                    exp_q.push_back({cur_addr, res_in[idx], lo});
                    cur_addr++;
                end
                idx++;
            end

            start_v[s] = (cyc == dup_cyc);
            @(posedge clk); #1;
            cyc++;
        end

        valid_v[s] = 1'b0;
        ack_v[s]   = 1'b0;
        start_v[s] = 1'b0;
        check("no_timeout", 48'(cyc < 2000), 48'd1);
        check("done_pulses", 48'(ndone), 48'd1);
        check("write_count", 48'(nwr), 48'((n + 1) / 2));
        check("results_consumed", 48'(idx), 48'(n));
        check("sb_drained", 48'(exp_q.size()), 48'd0);
        check("idle_after_job", {46'd0, o_busy, o_wr_en}, 48'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            valid_v[i] = 1'b0;
            data_v[i]  = '0;
            ack_v[i]   = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        n_rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("quiet_after_release");

        res_in.delete();
        for (int i = 1; i <= 10; i++) res_in.push_back(16'(i));
        run_job(0, 16'h0400, 10, 0, 1'b0, -1, -1);
        run_job(0, 16'h0400, 10, 4, 1'b0, -1, -1);
        run_job(0, 16'h0400, 10, 0, 1'b1, -1, -1);
        run_job(0, 16'h0400, 10, 0, 1'b0, 2, -1);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("quiet_after_abort");
        run_job(0, 16'h0400, 10, 1, 1'b0, -1, -1);

        res_in.delete();
        res_in.push_back(16'hAAAA);
        res_in.push_back(16'hBBBB);
        res_in.push_back(16'hCCCC);
        run_job(1, 16'h0400, 3, 0, 1'b0, -1, -1);

        res_in.delete();
        for (int i = 0; i < 4; i++) res_in.push_back(16'h1000 + 16'(i));
        run_job(2, 16'hFFFF, 4, 1, 1'b0, -1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
